thee_phase_seq: RTL
===================

# thee_phase_seq

Synchronous controller that sequences a two-phase non-overlapping clock pair (`clkp0`/`clkp1`) from one master clock, with programmable phase width and dead time counted in master-clock cycles. It starts and stops the pair cleanly, so a phase pulse is never truncated and the two phases never overlap. It sits between configuration/enable logic and the phase-clocked datapath (latch pairs, switched-capacitor stages) and is the cycle-accurate counterpart of the analog delay-based phase generator.

## Interface
- `CW`, 8: width of phase-length and dead-time fields.
- `PCW`, 16: width of the completed-period counter.

- `clkin`  in  1  master clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  run request; level-sensitive.
- `ph_len`  in  CW  phase high time minus 1, in cycles. 0 gives 1 cycle.
- `dead_len`  in  CW  dead time between phases, in cycles. 0 is treated as 1.
- `clkp0`  out  1  phase 0; registered.
- `clkp1`  out  1  phase 1; registered.
- `busy`  out  1  high whenever state is not IDLE.
- `periods`  out  PCW  count of completed full periods; wraps.

## Operation
- Reset: synchronous, active-low, on `clkin`.
  - Next state is IDLE.
  - `clkp0`=0, `clkp1`=0, `busy`=0, `periods`=0.
  - Shadow config registers = 0; `stop_req`=0.
- States: IDLE, P0, D01, P1, D10.
- `clkp0`=1 only in P0. `clkp1`=1 only in P1. Both are 0 in all other states, so they are never both 1.
- IDLE→P0: `en`=1 is sampled in IDLE. The shadow registers capture `ph_len` and `max(dead_len,1)`.
- P0→D01: after `ph_len_s+1` cycles in P0.
- D01→P1: after `dead_s` cycles in D01.
- P1→D10: after `ph_len_s+1` cycles in P1.
- D10→P0: after `dead_s` cycles, if `stop_req`=0. The shadow registers reload from the inputs on this transition.
- D10→IDLE: on the same condition, if `stop_req`=1.
- D01→IDLE: if `stop_req`=1 when D01 expires. P1 is not entered.
- `stop_req`:
  - Set on any cycle with `en`=0 while not IDLE.
  - Held until IDLE is entered; cleared in IDLE.
  - A later `en`=1 does not cancel it.
- Stop rule: the active phase and its following dead period always complete; then the controller goes to IDLE.
- Config timing: `ph_len`/`dead_len` changes take effect only at a period boundary (D10→P0) or at start. There is no mid-period change.
- `periods`: increments by 1 on every D10 exit (to P0 or IDLE). It wraps from 2^PCW−1 to 0.
- A single down-counter (CW bits) times every state. It is reloaded on each state entry.

## Timing
- Start latency: `en`=1 sampled at edge t (state IDLE) → `clkp0`=1 from edge t+1.
- Period = 2·(`ph_len_s`+1) + 2·`dead_s` cycles. Minimum is 4 (`ph_len`=0, `dead_len`≤1).
- The `clkp0` falling edge and the `clkp1` rising edge are separated by exactly `dead_s` cycles. The same holds for `clkp1`→`clkp0`.
- `busy`:
  - Rises at the same edge as the first `clkp0`.
  - Falls at the edge where D01 or D10 exits to IDLE.
- Restart: from IDLE with `en`=1, P0 is re-entered on the next edge. The minimum gap between the last phase falling and the new `clkp0` rising is `dead_s`+1 cycles.
- Reset mid-operation: all outputs read 0 on the edge where `rst_n`=0 is sampled. A truncated phase is acceptable only under reset.

## Test plan
- Reset: `rst_n`=0 for 3 cycles mid-P1 → at the next edge `clkp0`=`clkp1`=0, `busy`=0, `periods`=0. Outputs stay at 0 with `en`=0 after release.
- Basic run: `ph_len`=2, `dead_len`=1, `en`=1 → `clkp0` high 3 cycles, both low 1 cycle, `clkp1` high 3 cycles, both low 1 cycle. Period 8. `periods` reads 1, 2, 3 at cycles 8, 16, 24 after start.
- Dead-time clamp: `ph_len`=0, `dead_len`=0 → period 4: `clkp0` 1 cycle, gap 1, `clkp1` 1 cycle, gap 1. `clkp0`&`clkp1` is never 1; check with an assertion over 1000 cycles.
- Graceful stop: `ph_len`=3, `dead_len`=2, `en` dropped during the 2nd cycle of P1 → P1 lasts the full 4 cycles, D10 lasts 2 cycles, then IDLE. `busy`=0, `periods` +1, no further `clkp0`.
  - Repeat with `en` dropped in P0 → D01 completes, then IDLE. `clkp1` is never asserted and `periods` is unchanged.
- Config shadowing: run at `ph_len`=2, change to 5 during P1 → the remainder of that period uses 3-cycle phases; the next P0 is 6 cycles.
- Counter wrap: `ph_len`=0, `dead_len`=1, `PCW`=4 override → after 16 periods (64 cycles) `periods` returns to 0 and continues at 1.

Source files
------------

// File: rtl/thee_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module   : thee_phase_seq
//  Brief    : Two-phase non-overlapping clock sequencer with programmable
//             phase width and dead time, counted in master-clock cycles.
//             Starts and stops cleanly; phases are never truncated except
//             by reset.
//  Revision : 1.0  initial release
// ============================================================================
module thee_phase_seq #(
    parameter int CW  = 8,
    parameter int PCW = 16
) (
    input  logic           clkin,
    input  logic           rst_n,
    input  logic           en,
    input  logic [CW-1:0]  ph_len,
    input  logic [CW-1:0]  dead_len,
    output logic           clkp0,
    output logic           clkp1,
    output logic           busy,
    output logic [PCW-1:0] periods
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_p0   = 3'd1;
    localparam logic [2:0] c_d01  = 3'd2;
    localparam logic [2:0] c_p1   = 3'd3;
    localparam logic [2:0] c_d10  = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [CW-1:0]  r_ph_s;
    logic [CW-1:0]  r_dead_s;
    logic [CW-1:0]  w_dead_in;
    logic           r_stop_req;
    logic           r_clkp0;
    logic           r_clkp1;
    logic [PCW-1:0] r_periods;
    logic           w_load_cfg;
    logic           w_period_done;
    logic           w_cnt_zero;

    // A zero dead time would let the phases touch, so it is clamped to one.
    assign w_dead_in  = (dead_len == '0) ? CW'(1) : dead_len;
    assign w_cnt_zero = (r_cnt == '0);

    // Next-state logic: one down-counter times every state, reloaded on entry.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load_cfg    = 1'b0;
        w_period_done = 1'b0;
        case (r_state)
            c_idle: begin
                if (en) begin
                    w_state_nxt = c_p0;
                    w_cnt_nxt   = ph_len;
                    w_load_cfg  = 1'b1;
                end
            end
            c_p0: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_d01;
                    w_cnt_nxt   = r_dead_s - CW'(1);
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            c_d01: begin
                if (w_cnt_zero) begin
                    // A pending stop ends the run here so P1 is never started.
                    if (r_stop_req) begin
                        w_state_nxt = c_idle;
                    end else begin
                        w_state_nxt = c_p1;
                        w_cnt_nxt   = r_ph_s;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            c_p1: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_d10;
                    w_cnt_nxt   = r_dead_s - CW'(1);
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            c_d10: begin
                if (w_cnt_zero) begin
                    w_period_done = 1'b1;
                    if (r_stop_req) begin
                        w_state_nxt = c_idle;
                    end else begin
                        // Period boundary: the only point new config is taken.
                        w_state_nxt = c_p0;
                        w_cnt_nxt   = ph_len;
                        w_load_cfg  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // State, counter, shadow config, stop latch and registered phase outputs.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_ph_s     <= '0;
            r_dead_s   <= '0;
            r_stop_req <= 1'b0;
            r_clkp0    <= 1'b0;
            r_clkp1    <= 1'b0;
            r_periods  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_cfg) begin
                r_ph_s   <= ph_len;
                r_dead_s <= w_dead_in;
            end
            if (r_state == c_idle) begin
                r_stop_req <= 1'b0;
            end else if (!en) begin
                r_stop_req <= 1'b1;
            end
            if (w_period_done) begin
                r_periods <= r_periods + PCW'(1);
            end
            r_clkp0 <= (w_state_nxt == c_p0);
            r_clkp1 <= (w_state_nxt == c_p1);
        end
    end

    assign clkp0   = r_clkp0;
    assign clkp1   = r_clkp1;
    assign busy    = (r_state != c_idle);
    assign periods = r_periods;

endmodule
`default_nettype wire
